// File: rtl/snoop_pkg.sv
// Shared encodings for the snoop line controller: bus op codes, line coherence
// states and FSM states.
package snoop_pkg;

    typedef enum logic [1:0] {
        OP_READ_MISS  = 2'b00,
        OP_INVALIDATE = 2'b01,
        OP_WRITE_MISS = 2'b10,
        OP_NOTHING    = 2'b11
    } snoop_op_t;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_M = 2'd2,
        ST_E = 2'd3
    } line_state_t;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_FLUSH  = 2'd2,
        FSM_RESP   = 2'd3
    } fsm_state_t;

    // Without MESI support an Exclusive fill is stored as Shared.
    function automatic logic [1:0] coerce_state(input logic [1:0] raw, input logic mesi_en);
        if (!mesi_en && raw == ST_E) begin
            return ST_S;
        end
        return raw;
    endfunction

endpackage

// File: rtl/snoop_next_state.sv
// Coherence transition for one snooped line: (prior state, op, hit) ->
// (next state, write-back needed, requester must load Shared).
module snoop_next_state
    import snoop_pkg::*;
#(
    parameter int MESI = 0
) (
    input  logic [1:0] prior_state,
    input  logic [1:0] op,
    input  logic       hit,
    output logic [1:0] next_state,
    output logic       flush,
    output logic       shared
);

    logic [1:0] prior_eff;

    always_comb begin
        prior_eff  = coerce_state(prior_state, MESI != 0);
        next_state = prior_eff;
        flush      = 1'b0;
        shared     = 1'b0;
        if (hit) begin
            case (op)
                OP_READ_MISS: begin
                    next_state = ST_S;
                    flush      = (prior_eff == ST_M);
                    shared     = 1'b1;
                end
                OP_WRITE_MISS: begin
                    next_state = ST_I;
                    flush      = (prior_eff == ST_M);
                end
                OP_INVALIDATE: begin
                    // Invalidate only comes from an upgrade of a line we share, so no data moves.
                    next_state = ST_I;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/snoop_line_controller.sv
// Per-line MSI/MESI state and tag store answering bus snoops; Modified hits
// trigger a write-back flush handshake before the snoop response.
module snoop_line_controller
    import snoop_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2,
    parameter int MESI    = 0
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_n,
    input  logic                      i_Snoop_Valid,
    output logic                      o_Snoop_Ready,
    input  logic [1:0]                i_Snoop_Op,
    input  logic [ADDR_W-1:0]         i_Snoop_Addr,
    input  logic                      i_Local_Valid,
    output logic                      o_Local_Ready,
    input  logic [INDEX_W-1:0]        i_Local_Index,
    input  logic [ADDR_W-INDEX_W-1:0] i_Local_Tag,
    input  logic [1:0]                i_Local_State,
    output logic                      o_Flush_Req,
    output logic [INDEX_W-1:0]        o_Flush_Index,
    input  logic                      i_Flush_Ack,
    output logic                      o_Done,
    output logic                      o_Hit,
    output logic                      o_Shared
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    fsm_state_t                  fsm_reg, fsm_next;
    logic [1:0]                  op_reg;
    logic [INDEX_W-1:0]          index_reg;
    logic [TAG_W-1:0]            tag_reg;
    logic                        hit_reg;
    logic                        shared_reg;
    logic [INDEX_W-1:0]          flush_index_reg;

    logic [LINES-1:0][1:0]       state_vec;
    logic [LINES-1:0][TAG_W-1:0] tag_vec;

    logic                        snoop_xfer;
    logic                        local_we;
    logic [1:0]                  local_state_c;
    logic [1:0]                  lookup_state;
    logic                        lookup_hit;
    logic [1:0]                  lookup_next;
    logic                        lookup_flush;
    logic                        lookup_shared;

    assign o_Snoop_Ready = (fsm_reg == FSM_IDLE);
    // A snoop presented in the same cycle always wins over a local write.
    assign o_Local_Ready = (fsm_reg == FSM_IDLE) && !i_Snoop_Valid;
    assign snoop_xfer    = i_Snoop_Valid && o_Snoop_Ready;
    assign local_we      = i_Local_Valid && o_Local_Ready;
    assign local_state_c = coerce_state(i_Local_State, MESI != 0);

    assign lookup_state  = state_vec[index_reg];
    assign lookup_hit    = (tag_vec[index_reg] == tag_reg) && (lookup_state != ST_I);

    snoop_next_state #(
        .MESI (MESI)
    ) u_next_state (
        .prior_state (lookup_state),
        .op          (op_reg),
        .hit         (lookup_hit),
        .next_state  (lookup_next),
        .flush       (lookup_flush),
        .shared      (lookup_shared)
    );

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            logic [1:0]       line_state_reg;
            logic [TAG_W-1:0] line_tag_reg;

            always_ff @(posedge i_Clock or negedge i_Reset_n) begin
                if (!i_Reset_n) begin
                    line_state_reg <= ST_I;
                    line_tag_reg   <= '0;
                end else if (local_we && i_Local_Index == INDEX_W'(gi)) begin
                    line_state_reg <= local_state_c;
                    line_tag_reg   <= i_Local_Tag;
                end else if (fsm_reg == FSM_LOOKUP && index_reg == INDEX_W'(gi)) begin
                    line_state_reg <= lookup_next;
                end
            end

            assign state_vec[gi] = line_state_reg;
            assign tag_vec[gi]   = line_tag_reg;
        end
    endgenerate

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            FSM_IDLE:   if (i_Snoop_Valid) fsm_next = FSM_LOOKUP;
            FSM_LOOKUP: fsm_next = lookup_flush ? FSM_FLUSH : FSM_RESP;
            FSM_FLUSH:  if (i_Flush_Ack) fsm_next = FSM_RESP;
            FSM_RESP:   fsm_next = FSM_IDLE;
            default:    fsm_next = FSM_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            fsm_reg         <= FSM_IDLE;
            op_reg          <= OP_NOTHING;
            index_reg       <= '0;
            tag_reg         <= '0;
            hit_reg         <= 1'b0;
            shared_reg      <= 1'b0;
            flush_index_reg <= '0;
        end else begin
            fsm_reg <= fsm_next;
            if (snoop_xfer) begin
                op_reg    <= i_Snoop_Op;
                index_reg <= i_Snoop_Addr[INDEX_W-1:0];
                tag_reg   <= i_Snoop_Addr[ADDR_W-1:INDEX_W];
            end
            if (fsm_reg == FSM_LOOKUP) begin
                hit_reg         <= lookup_hit;
                shared_reg      <= lookup_shared;
                flush_index_reg <= index_reg;
            end
        end
    end

    // Outputs decode straight from registered state so reset clears them asynchronously.
    assign o_Flush_Req   = (fsm_reg == FSM_FLUSH);
    assign o_Flush_Index = flush_index_reg;
    assign o_Done        = (fsm_reg == FSM_RESP);
    assign o_Hit         = o_Done && hit_reg;
    assign o_Shared      = o_Done && shared_reg;

endmodule

// File: tb/tb_snoop_line_controller.sv
// Scoreboard bench for snoop_line_controller: directed snoops push expected
// responses, a monitor pops and compares on every o_Done.
module tb_snoop_line_controller;
    import snoop_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = ADDR_W - INDEX_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               snoop_valid = 1'b0;
    logic [1:0]         snoop_op = 2'b11;
    logic [ADDR_W-1:0]  snoop_addr = '0;
    logic               local_valid = 1'b0;
    logic [INDEX_W-1:0] local_index = '0;
    logic [TAG_W-1:0]   local_tag = '0;
    logic [1:0]         local_state = '0;
    logic               flush_ack = 1'b0;

    logic               snoop_ready, local_ready, flush_req, done, hit, shared;
    logic [INDEX_W-1:0] flush_index;
    logic               e_snoop_ready, e_local_ready, e_flush_req, e_done, e_hit, e_shared;
    logic [INDEX_W-1:0] e_flush_index;

    always #5 clk = ~clk;

    snoop_line_controller #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .MESI(0)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Snoop_Valid(snoop_valid), .o_Snoop_Ready(snoop_ready),
        .i_Snoop_Op(snoop_op), .i_Snoop_Addr(snoop_addr),
        .i_Local_Valid(local_valid), .o_Local_Ready(local_ready),
        .i_Local_Index(local_index), .i_Local_Tag(local_tag), .i_Local_State(local_state),
        .o_Flush_Req(flush_req), .o_Flush_Index(flush_index), .i_Flush_Ack(flush_ack),
        .o_Done(done), .o_Hit(hit), .o_Shared(shared)
    );

    snoop_line_controller #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .MESI(1)) dut_e (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Snoop_Valid(snoop_valid), .o_Snoop_Ready(e_snoop_ready),
        .i_Snoop_Op(snoop_op), .i_Snoop_Addr(snoop_addr),
        .i_Local_Valid(local_valid), .o_Local_Ready(e_local_ready),
        .i_Local_Index(local_index), .i_Local_Tag(local_tag), .i_Local_State(local_state),
        .o_Flush_Req(e_flush_req), .o_Flush_Index(e_flush_index), .i_Flush_Ack(flush_ack),
        .o_Done(e_done), .o_Hit(e_hit), .o_Shared(e_shared)
    );

    typedef struct {
        logic       hit;
        logic       shared;
        logic       flush;
        logic [1:0] fidx;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   ack_delay = 3;
    int   fcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Write-back responder: acks in the ack_delay-th FLUSH cycle (0 = never).
    always @(negedge clk) begin
        if (flush_req) begin
            fcnt++;
            flush_ack = (fcnt == ack_delay);
        end else begin
            fcnt = 0;
            flush_ack = 1'b0;
        end
    end

    // Monitor: latency counted in rising edges from the transfer edge to o_Done.
    bit         xfer, busy, fseen;
    int         cyc;
    logic [1:0] fidx_seen;
    exp_t       mon_e;
    always @(posedge clk) begin
        xfer = snoop_valid && snoop_ready && rst_n;
        #1;
        if (!rst_n) begin
            busy  = 0;
            fseen = 0;
        end else begin
            if (busy) cyc++;
            if (xfer) begin
                busy = 1;
                cyc  = 1;
            end
            if (flush_req) begin
                if (!fseen) begin
                    fseen     = 1;
                    fidx_seen = flush_index;
                end else if (flush_index !== fidx_seen) begin
                    check("flush_index_stable", flush_index, fidx_seen);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("hit", hit, mon_e.hit);
                    check("shared", shared, mon_e.shared);
                    check("flushed", fseen, mon_e.flush);
                    if (mon_e.flush) check("flush_index", fidx_seen, mon_e.fidx);
                    check("latency", cyc, mon_e.lat);
                    $display("snoop done: hit=%0b shared=%0b flushed=%0b latency=%0d", hit, shared, fseen, cyc);
                end
                busy  = 0;
                fseen = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (snoop_ready) return;
        end
        check("idle_timeout", snoop_ready, 1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        check("done_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic snoop(input logic [1:0] op, input logic [7:0] addr, input logic h,
                         input logic sh, input logic fl, input logic [1:0] fi, input bit wait_done);
        exp_t e;
        wait_idle();
        e.hit = h; e.shared = sh; e.flush = fl; e.fidx = fi;
        e.lat = fl ? 2 + ack_delay : 2;
        exp_q.push_back(e);
        snoop_valid = 1'b1; snoop_op = op; snoop_addr = addr;
        @(negedge clk);
        snoop_valid = 1'b0; snoop_op = OP_NOTHING;
        if (wait_done) wait_drain();
    endtask

    task automatic local_hold();
        bit accepted = 0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (local_ready) begin
                @(posedge clk);
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) check("local_timeout", local_ready, 1);
        @(negedge clk);
        local_valid = 1'b0;
    endtask

    task automatic local_write(input logic [1:0] idx, input logic [5:0] tag, input logic [1:0] st);
        @(negedge clk);
        local_valid = 1'b1; local_index = idx; local_tag = tag; local_state = st;
        $display("local write: idx=%0d tag=%0h state=%0d", idx, tag, st);
        local_hold();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_snoop_ready", snoop_ready, 1);
        check("rst_local_ready", local_ready, 1);
        check("rst_flush_req", flush_req, 0);
        check("rst_flush_index", flush_index, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_shared", shared, 0);
        check("rst_lines", dut.state_vec, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Miss on empty cache
        snoop(OP_READ_MISS, 8'h05, 0, 0, 0, 2'd0, 1);

        // Modified hit on READ_MISS: flush with ack in the third FLUSH cycle, line -> S
        local_write(2'd1, 6'h01, ST_M);
        snoop(OP_READ_MISS, 8'h05, 1, 1, 1, 2'd1, 1);
        check("line1_after_rm", dut.state_vec[1], ST_S);
        snoop(OP_READ_MISS, 8'h05, 1, 1, 0, 2'd0, 1);

        // Shared hit on WRITE_MISS: no flush, line -> I, then miss
        local_write(2'd2, 6'h03, ST_S);
        snoop(OP_WRITE_MISS, 8'h0E, 1, 0, 0, 2'd0, 1);
        check("line2_after_wm", dut.state_vec[2], ST_I);
        snoop(OP_WRITE_MISS, 8'h0E, 0, 0, 0, 2'd0, 1);

        // INVALIDATE on Modified: no flush
        local_write(2'd1, 6'h01, ST_M);
        snoop(OP_INVALIDATE, 8'h05, 1, 0, 0, 2'd0, 1);
        check("line1_after_inv", dut.state_vec[1], ST_I);

        // NOTHING reports the match without changing state; tag mismatch is a miss
        local_write(2'd2, 6'h03, ST_S);
        snoop(OP_NOTHING, 8'h0E, 1, 0, 0, 2'd0, 1);
        check("line2_after_nothing", dut.state_vec[2], ST_S);
        snoop(OP_READ_MISS, 8'h12, 0, 0, 0, 2'd0, 1);
        check("line2_after_tag_miss", dut.state_vec[2], ST_S);

        // WRITE_MISS on Modified with ack in the first FLUSH cycle
        local_write(2'd1, 6'h01, ST_M);
        ack_delay = 1;
        snoop(OP_WRITE_MISS, 8'h05, 1, 0, 1, 2'd1, 1);
        check("line1_after_wm_m", dut.state_vec[1], ST_I);
        ack_delay = 3;

        // Exclusive fill: coerced to S without MESI, kept E with MESI, read-miss drops it to S
        local_write(2'd0, 6'h00, ST_E);
        check("msi_e_coerced", dut.state_vec[0], ST_S);
        check("mesi_e_stored", dut_e.state_vec[0], ST_E);
        snoop(OP_READ_MISS, 8'h00, 1, 1, 0, 2'd0, 1);
        check("mesi_e_to_s", dut_e.state_vec[0], ST_S);

        // Snoop and local write in the same cycle to the same line: snoop first
        wait_idle();
        begin
            exp_t e;
            e.hit = 0; e.shared = 0; e.flush = 0; e.fidx = 2'd0; e.lat = 2;
            exp_q.push_back(e);
        end
        snoop_valid = 1'b1; snoop_op = OP_READ_MISS; snoop_addr = 8'h0B;
        local_valid = 1'b1; local_index = 2'd3; local_tag = 6'h02; local_state = ST_S;
        #1;
        check("conflict_local_ready", local_ready, 0);
        check("conflict_snoop_ready", snoop_ready, 1);
        @(negedge clk);
        snoop_valid = 1'b0; snoop_op = OP_NOTHING;
        local_hold();
        wait_drain();
        check("line3_local_later", dut.state_vec[3], ST_S);
        snoop(OP_READ_MISS, 8'h0B, 1, 1, 0, 2'd0, 1);

        // Reset during FLUSH
        local_write(2'd1, 6'h01, ST_M);
        ack_delay = 0;
        snoop(OP_READ_MISS, 8'h05, 1, 1, 1, 2'd1, 0);
        for (int n = 0; n < 20; n++) begin
            if (flush_req) break;
            @(negedge clk);
        end
        check("flush_started", flush_req, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midflush_rst_flush_req", flush_req, 0);
        check("midflush_rst_snoop_ready", snoop_ready, 1);
        check("midflush_rst_done", done, 0);
        check("midflush_rst_lines", dut.state_vec, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 3;
        snoop(OP_READ_MISS, 8'h05, 0, 0, 0, 2'd0, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
